// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_stage
//  Description : Execute stage with single-cycle ALU ops and a 16-step
//                shift-add multiplier, writing results to the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [ADDR_W-1:0] rd,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              zero,
   output logic              ovf,
   output logic              busy
);

   localparam logic [3:0] c_OP_ADD = 4'd0;
   localparam logic [3:0] c_OP_SUB = 4'd1;
   localparam logic [3:0] c_OP_AND = 4'd2;
   localparam logic [3:0] c_OP_OR  = 4'd3;
   localparam logic [3:0] c_OP_XOR = 4'd4;
   localparam logic [3:0] c_OP_SLL = 4'd5;
   localparam logic [3:0] c_OP_SRL = 4'd6;
   localparam logic [3:0] c_OP_SRA = 4'd7;
   localparam logic [3:0] c_OP_SLT = 4'd8;
   localparam logic [3:0] c_OP_MUL = 4'd9;
   localparam logic [3:0] c_LAST_STEP = 4'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [DATA_W-1:0]   mcand_q, mcand_d;
   logic [DATA_W-1:0]   mplier_q, mplier_d;
   logic [ADDR_W-1:0]   rd_q, rd_d;
   logic                wb_en_q, wb_en_d;
   logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0]   wb_data_q, wb_data_d;
   logic                zero_q, zero_d;
   logic                ovf_q, ovf_d;

   logic [DATA_W-1:0]   w_sum, w_diff, w_alu_res;
   logic                w_add_ovf, w_sub_ovf, w_alu_ovf;

   assign w_sum     = a + b;
   assign w_diff    = a - b;
   assign w_add_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (w_sum[DATA_W-1] != a[DATA_W-1]);
   assign w_sub_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (w_diff[DATA_W-1] != a[DATA_W-1]);

   always_comb begin
      w_alu_res = '0;
      w_alu_ovf = 1'b0;
      case (op)
         c_OP_ADD: begin w_alu_res = w_sum;  w_alu_ovf = w_add_ovf; end
         c_OP_SUB: begin w_alu_res = w_diff; w_alu_ovf = w_sub_ovf; end
         c_OP_AND: w_alu_res = a & b;
         c_OP_OR:  w_alu_res = a | b;
         c_OP_XOR: w_alu_res = a ^ b;
         c_OP_SLL: w_alu_res = a << b[3:0];
         c_OP_SRL: w_alu_res = a >> b[3:0];
         c_OP_SRA: w_alu_res = $unsigned($signed(a) >>> b[3:0]);
         c_OP_SLT: w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         default:  w_alu_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      rd_d      = rd_q;
      wb_en_d   = 1'b0;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      zero_d    = zero_q;
      ovf_d     = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (op == c_OP_MUL) begin
                  state_d  = S_MUL;
                  cnt_d    = '0;
                  acc_d    = '0;
                  mcand_d  = a;
                  mplier_d = b;
                  rd_d     = rd;
               end else if (op <= c_OP_SLT) begin
                  wb_en_d   = 1'b1;
                  wb_addr_d = rd;
                  wb_data_d = w_alu_res;
                  zero_d    = (w_alu_res == '0);
                  ovf_d     = w_alu_ovf;
               end
            end
         end
         S_MUL: begin
            // One multiplier bit per edge; the low DATA_W product bits survive.
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == c_LAST_STEP) begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd_q;
            wb_data_d = acc_q;
            zero_d    = (acc_q == '0);
            ovf_d     = 1'b0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         rd_q      <= '0;
         wb_en_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         zero_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         rd_q      <= rd_d;
         wb_en_q   <= wb_en_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         zero_q    <= zero_d;
         ovf_q     <= ovf_d;
      end
   end

   assign in_ready = (state_q == S_IDLE) && !rst;
   assign busy     = (state_q != S_IDLE);
   assign wb_en    = wb_en_q;
   assign wb_addr  = wb_addr_q;
   assign wb_data  = wb_data_q;
   assign zero     = zero_q;
   assign ovf      = ovf_q;

endmodule
`default_nettype wire
